// File: rtl/alu_pkg.sv
// Shared constants for the pipelined ALU: data width and 4-bit opcode encodings.
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_NOT = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOR = 4'h6;
    localparam logic [3:0] OP_SLL = 4'h7;
    localparam logic [3:0] OP_SRL = 4'h8;
    localparam logic [3:0] OP_SRA = 4'h9;
    localparam logic [3:0] OP_ROL = 4'hA;
    localparam logic [3:0] OP_ROR = 4'hB;
    localparam logic [3:0] OP_EQ  = 4'hC;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: opcode decode producing an 8-bit result and carry flag.
module alu_core
    import alu_pkg::*;
(
    input  logic [3:0]        ctrl,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic              carry,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W:0] sum9;
    logic [DATA_W:0] diff9;

    // Carry is bit 8 of the sign-extended result, i.e. the sign of the true result.
    assign sum9  = {x[DATA_W-1], x} + {y[DATA_W-1], y};
    assign diff9 = {x[DATA_W-1], x} - {y[DATA_W-1], y};

    always_comb begin
        carry = 1'b0;
        out   = '0;
        case (ctrl)
            OP_ADD: begin
                out   = sum9[DATA_W-1:0];
                carry = sum9[DATA_W];
            end
            OP_SUB: begin
                out   = diff9[DATA_W-1:0];
                carry = diff9[DATA_W];
            end
            OP_AND:  out = x & y;
            OP_OR:   out = x | y;
            OP_NOT:  out = ~x;
            OP_XOR:  out = x ^ y;
            OP_NOR:  out = ~(x | y);
            OP_SLL:  out = y << x[2:0];
            OP_SRL:  out = y >> x[2:0];
            OP_SRA:  out = {x[DATA_W-1], x[DATA_W-1:1]};
            OP_ROL:  out = {x[DATA_W-2:0], x[DATA_W-1]};
            OP_ROR:  out = {x[0], x[DATA_W-1:1]};
            OP_EQ:   out = {{(DATA_W-1){1'b0}}, (x == y)};
            default: begin
                out   = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// ALU with request/response handshake and a 2-entry registered result FIFO.
// Define ALU_PIPE_STATS_EN to add the saturating op_count port.
module alu_pipe
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        ctrl,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out,
    output logic              carry
`ifdef ALU_PIPE_STATS_EN
    ,
    output logic [15:0]       op_count
`endif
);

    logic [DATA_W:0]   alu_res;
    logic [DATA_W:0]   head_q;
    logic [DATA_W:0]   tail_q;
    logic [1:0]        count_q;
    logic              push;
    logic              pop;

    alu_core u_core (
        .ctrl  (ctrl),
        .x     (x),
        .y     (y),
        .carry (alu_res[DATA_W]),
        .out   (alu_res[DATA_W-1:0])
    );

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out       = head_q[DATA_W-1:0];
    assign carry     = head_q[DATA_W];

    // Empty entries are kept at zero so the head reads 0/0 whenever the FIFO is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= alu_res;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= alu_res;
                    end else if (push) begin
                        tail_q  <= alu_res;
                        count_q <= 2'd2;
                    end else if (pop) begin
                        head_q  <= '0;
                        count_q <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        tail_q  <= '0;
                        count_q <= 2'd1;
                    end
                end
            endcase
        end
    end

`ifdef ALU_PIPE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= 16'd0;
        end else if (push && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule
